// File: rtl/d_result_collector_pkg.sv
//------------------------------------------------------------------------------
// Module   : d_result_collector_pkg
// Brief    : Shared lane geometry, lane-order constants and FSM state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package d_result_collector_pkg;

  localparam int LANES  = 8;
  localparam int DATA_W = 64;

  // Lane index of each tensor-core / octet / threadgroup slice within a beat
  localparam int c_TC0_OCT0_TG0 = 0;
  localparam int c_TC0_OCT0_TG4 = 1;
  localparam int c_TC0_OCT1_TG0 = 2;
  localparam int c_TC0_OCT1_TG4 = 3;
  localparam int c_TC1_OCT0_TG0 = 4;
  localparam int c_TC1_OCT0_TG4 = 5;
  localparam int c_TC1_OCT1_TG0 = 6;
  localparam int c_TC1_OCT1_TG4 = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/d_result_buffer.sv
//------------------------------------------------------------------------------
// Module   : d_result_buffer
// Brief    : Wide-write, lane-narrow registered-read result RAM with count mask.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module d_result_buffer #(
  parameter int LANES  = d_result_collector_pkg::LANES,
  parameter int DATA_W = d_result_collector_pkg::DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH * LANES),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_beat,
  input  logic [LANES*DATA_W-1:0]   wr_data,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [CNT_W-1:0]          valid_count,
  output logic [DATA_W-1:0]         rd_data
);

  import d_result_collector_pkg::*;

  localparam int LANE_W = $clog2(LANES);
  localparam int BEAT_W = $clog2(DEPTH);

  logic [LANES*DATA_W-1:0] r_mem [DEPTH];

  logic [BEAT_W-1:0]       w_rd_beat;
  logic [LANE_W-1:0]       w_rd_lane;
  logic [LANES*DATA_W-1:0] w_rd_row;
  logic [DATA_W-1:0]       w_rd_lane_data;
  logic                    w_rd_valid;

  assign w_rd_beat      = rd_addr[ADDR_W-1:LANE_W];
  assign w_rd_lane      = rd_addr[LANE_W-1:0];
  assign w_rd_row       = r_mem[w_rd_beat];
  assign w_rd_lane_data = w_rd_row[w_rd_lane*DATA_W +: DATA_W];
  // Slots at or beyond the captured count read as zero, hiding stale contents
  assign w_rd_valid     = CNT_W'(w_rd_beat) < valid_count;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[wr_beat] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= w_rd_valid ? w_rd_lane_data : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/d_result_collector.sv
//------------------------------------------------------------------------------
// Module   : d_result_collector
// Brief    : Consumes the io_out stream into a result buffer for host readback.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module d_result_collector #(
  parameter int LANES  = d_result_collector_pkg::LANES,
  parameter int DATA_W = d_result_collector_pkg::DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH * LANES),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_start,
  input  logic [CNT_W-1:0]        io_num_beats,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic [LANES*DATA_W-1:0] io_in_bits,
  input  logic                    io_rd_en,
  input  logic [ADDR_W-1:0]       io_rd_addr,
  output logic [DATA_W-1:0]       io_rd_data,
  output logic [CNT_W-1:0]        io_count,
  output logic                    io_busy,
  output logic                    io_done
);

  import d_result_collector_pkg::*;

  localparam int               BEAT_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] w_target_clamped;
  logic             w_fire;
  logic             w_last;

  always_comb begin
    w_target_clamped = io_num_beats;
    if (io_num_beats == '0) begin
      w_target_clamped = c_ONE;
    end else if (io_num_beats > c_DEPTH) begin
      w_target_clamped = c_DEPTH;
    end
  end

  // Ready drops on a restart pulse so the restart cycle never accepts a beat
  assign io_in_ready = (r_state == COLLECT) && !io_start;
  assign w_fire      = io_in_valid && io_in_ready;
  assign w_last      = (r_count + c_ONE) == r_target;

  assign io_busy  = (r_state == COLLECT);
  assign io_done  = (r_state == DONE);
  assign io_count = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_target <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (io_start) begin
            r_state  <= COLLECT;
            r_count  <= '0;
            r_target <= w_target_clamped;
          end
        end
        COLLECT: begin
          if (io_start) begin
            r_count  <= '0;
            r_target <= w_target_clamped;
          end else if (w_fire) begin
            r_count <= r_count + c_ONE;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  d_result_buffer #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_buffer (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (w_fire),
    .wr_beat     (r_count[BEAT_W-1:0]),
    .wr_data     (io_in_bits),
    .rd_en       (io_rd_en),
    .rd_addr     (io_rd_addr),
    .valid_count (r_count),
    .rd_data     (io_rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_d_result_collector.sv
//------------------------------------------------------------------------------
// Module   : tb_d_result_collector
// Brief    : Directed self-checking bench for d_result_collector.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_d_result_collector;

  import d_result_collector_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH * LANES);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    io_start;
  logic [CNT_W-1:0]        io_num_beats;
  logic                    io_in_valid;
  logic                    io_in_ready;
  logic [LANES*DATA_W-1:0] io_in_bits;
  logic                    io_rd_en;
  logic [ADDR_W-1:0]       io_rd_addr;
  logic [DATA_W-1:0]       io_rd_data;
  logic [CNT_W-1:0]        io_count;
  logic                    io_busy;
  logic                    io_done;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  d_result_collector #(
    .DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (io_start),
    .io_num_beats (io_num_beats),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_rd_en     (io_rd_en),
    .io_rd_addr   (io_rd_addr),
    .io_rd_data   (io_rd_data),
    .io_count     (io_count),
    .io_busy      (io_busy),
    .io_done      (io_done)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [LANES*DATA_W-1:0] beat_of(input logic [63:0] base);
    logic [LANES*DATA_W-1:0] b;
    for (int k = 0; k < LANES; k++) b[k*DATA_W +: DATA_W] = base + 64'(k);
    return b;
  endfunction

  task automatic start_run(input int n);
    io_start     = 1'b1;
    io_num_beats = CNT_W'(n);
    cyc();
    io_start = 1'b0;
  endtask

  task automatic rd(input int addr, output logic [63:0] data);
    io_rd_en   = 1'b1;
    io_rd_addr = ADDR_W'(addr);
    cyc();
    io_rd_en = 1'b0;
    data     = io_rd_data;
  endtask

  initial begin
    logic [63:0] d;
    int          acc;
    logic        rose;

    reset = 1'b1; io_start = 1'b0; io_num_beats = '0; io_in_valid = 1'b0;
    io_in_bits = '0; io_rd_en = 1'b0; io_rd_addr = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(io_in_ready), 64'd0);
    check("rst_busy",  64'(io_busy),     64'd0);
    check("rst_done",  64'(io_done),     64'd0);
    check("rst_count", 64'(io_count),    64'd0);
    check("rst_rdata", io_rd_data,       64'd0);

    // Two back-to-back beats
    start_run(2);
    io_in_valid = 1'b1; io_in_bits = beat_of(64'h1000); #1;
    check("b2b_ready0", 64'(io_in_ready), 64'd1);
    cyc();
    io_in_bits = beat_of(64'h2000); #1;
    check("b2b_ready1", 64'(io_in_ready), 64'd1);
    cyc();
    check("b2b_ready_off", 64'(io_in_ready), 64'd0);
    io_in_valid = 1'b0;
    check("b2b_done",  64'(io_done),  64'd1);
    check("b2b_count", 64'(io_count), 64'd2);
    rd(1 * LANES + c_TC0_OCT0_TG4, d); check("b2b_rd9", d, 64'h2001);
    rd(0, d);  check("b2b_rd0", d, 64'h1000);
    rd(16, d); check("b2b_rd16_masked", d, 64'd0);

    // Gapped valid 1,0,1,0,1 with three expected beats
    start_run(3);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      io_in_valid = (i % 2 == 0);
      io_in_bits  = beat_of(64'h3000 + 64'(acc) * 64'h100);
      #1;
      if (io_in_valid && io_in_ready) acc++;
      if (i == 3) check("gap_not_done", 64'(io_done), 64'd0);
      cyc();
    end
    check("gap_accepted", 64'(acc), 64'd3);
    check("gap_done",  64'(io_done),  64'd1);
    check("gap_count", 64'(io_count), 64'd3);
    io_in_valid = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (io_in_ready) rose = 1'b1;
      cyc();
    end
    check("gap_ready_held_low", 64'(rose), 64'd0);
    io_in_valid = 1'b0;
    rd(2 * LANES + 5, d); check("gap_rd21", d, 64'h3205);

    // num_beats = 0 behaves as 1
    start_run(0);
    io_in_valid = 1'b1; io_in_bits = beat_of(64'h4000);
    cyc();
    #1;
    check("zero_done",  64'(io_done),     64'd1);
    check("zero_count", 64'(io_count),    64'd1);
    check("zero_ready", 64'(io_in_ready), 64'd0);
    io_in_valid = 1'b0;
    rd(3, d); check("zero_rd3", d, 64'h4003);
    rd(8, d); check("zero_rd8_stale_masked", d, 64'd0);

    // num_beats = 31 clamps to DEPTH
    start_run(31);
    acc = 0;
    io_in_valid = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      io_in_bits = beat_of(64'h5000 + 64'(acc) * 64'h100);
      #1;
      if (io_in_ready) acc++;
      cyc();
    end
    io_in_valid = 1'b0;
    check("clamp_accepted", 64'(acc), 64'd16);
    check("clamp_done",  64'(io_done),  64'd1);
    check("clamp_count", 64'(io_count), 64'd16);
    rd(127, d); check("clamp_rd127", d, 64'h5F07);

    // Restart mid-run while valid is held
    start_run(4);
    io_in_valid = 1'b1; io_in_bits = beat_of(64'h6000);
    cyc();
    check("rst_run_count1", 64'(io_count), 64'd1);
    io_start = 1'b1; io_num_beats = CNT_W'(4); io_in_bits = beat_of(64'h6100);
    #1;
    check("restart_ready", 64'(io_in_ready), 64'd0);
    cyc();
    io_start = 1'b0;
    check("restart_count", 64'(io_count), 64'd0);
    check("restart_busy",  64'(io_busy),  64'd1);
    io_in_bits = beat_of(64'h6200);
    cyc();
    check("restart_count_after", 64'(io_count), 64'd1);
    // Read of slot 1 while it is being written returns the masked value
    io_in_bits = beat_of(64'h6300);
    rd(8, d); check("restart_rd8_same_cycle", d, 64'd0);
    io_in_valid = 1'b0;
    rd(0, d); check("restart_rd0", d, 64'h6200);
    rd(8, d); check("restart_rd8_written", d, 64'h6300);

    // Reset mid-collection, then a single-beat run
    start_run(4);
    io_in_valid = 1'b1; io_in_bits = beat_of(64'h7000); cyc();
    io_in_bits = beat_of(64'h7100); cyc();
    io_in_valid = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    check("midrst_busy",  64'(io_busy),  64'd0);
    check("midrst_count", 64'(io_count), 64'd0);
    rd(0, d); check("midrst_rd0_masked", d, 64'd0);
    start_run(1);
    io_in_valid = 1'b1;
    for (int k = 0; k < LANES; k++) io_in_bits[k*DATA_W +: DATA_W] = 64'hAB;
    cyc();
    io_in_valid = 1'b0;
    check("midrst_done", 64'(io_done), 64'd1);
    rd(0, d); check("midrst_rd0", d, 64'hAB);
    rd(8, d); check("midrst_rd8", d, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/d_result_collector.md
Name: d_result_collector

Overview:
- Consumer end of the System `io_out` decoupled stream.
- Drives `io_out_ready` and captures each accepted beat of eight threadgroup `matrix_d_data` lanes into an internal result buffer.
- After a programmed number of beats it signals done.
- A host-side random-read port lets a bench or controller retrieve individual D elements for comparison against golden data.

Parameters:
- LANES, 8, number of matrix_d_data lanes per beat. Lane order is tc0_octet0_tg0, tc0_octet0_tg4, tc0_octet1_tg0, tc0_octet1_tg4, then the same four for tc1.
- DATA_W, 64, width of one lane's matrix_d_data.
- DEPTH, 16, maximum beats stored per run.
- ADDR_W, log2(DEPTH*LANES), read address width.
- CNT_W, log2(DEPTH)+1, beat counter width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- io_start  in  1  begin a collection run. Pulse; sampled every cycle.
- io_num_beats  in  CNT_W  beats expected in the run, sampled when io_start is accepted. Range 1..DEPTH.
- io_in_valid  in  1  System io_out_valid.
- io_in_ready  out  1  connects to System io_out_ready.
- io_in_bits  in  LANES*DATA_W  concatenated lanes, lane 0 in the LSBs.
- io_rd_en  in  1  host read request.
- io_rd_addr  in  ADDR_W  element index = beat*LANES + lane.
- io_rd_data  out  DATA_W  read result, valid one cycle after io_rd_en.
- io_count  out  CNT_W  beats captured in the current or last run.
- io_busy  out  1  high in COLLECT.
- io_done  out  1  high in DONE.

Behaviour:
- Reset values:
  - state=IDLE; io_in_ready=0, io_busy=0, io_done=0, io_count=0, io_rd_data=0.
  - Target beat register cleared.
  - Buffer contents are not reset; unwritten entries are masked on read (see reads).
- States:
  - IDLE: io_in_ready=0. io_start -> COLLECT; count:=0; target:=io_num_beats.
  - COLLECT: io_in_ready = !io_start.
    - A handshake (io_in_valid & io_in_ready) writes io_in_bits to beat slot count, then count:=count+1.
    - When the handshake completes beat target-1, next state is DONE.
    - io_start in COLLECT restarts the run: count:=0, target reloaded. No beat is accepted that cycle because ready is low.
  - DONE: io_in_ready=0, io_done=1. Contents and count are held. io_start -> COLLECT with the same restart semantics as from IDLE.
- Handshake rules:
  - io_in_ready does not depend on io_in_valid.
  - At most one beat is accepted per cycle.
  - Back-to-back beats are accepted at full rate.
- Target clamping:
  - io_num_beats=0 is treated as 1.
  - Values greater than DEPTH are clamped to DEPTH.
  - The buffer never overflows or wraps.
- Reads:
  - Registered; io_rd_data is updated on the cycle after io_rd_en and held otherwise.
  - If addr/LANES >= count, io_rd_data=0. Partial runs and fresh runs therefore never expose stale data.
  - A read of the slot being written in the same cycle returns the old masked value, i.e. 0, because count has not yet advanced.
  - Reads are allowed in every state.
- Mid-run reset: synchronous reset forces IDLE and clears count. Subsequent reads return 0 until new beats arrive.

Decomposition:
- Shared package holds:
  - LANES, DATA_W, and the lane-order constants (lane index per tc/octet/threadgroup).
  - State enum {IDLE, COLLECT, DONE}.
- One natural sub-module, d_result_buffer: DEPTH x (LANES*DATA_W) write-wide, read-narrow synchronous RAM with lane mux and valid-count masking.
- The FSM and counters live in the top level.

Test Plan:
- Reset, then start with num_beats=2. Drive two back-to-back valid beats with lane k = 0x1000+k and 0x2000+k.
  - Required: ready high for 2 cycles, then done=1 and count=2.
  - Reading addr 9 returns 0x2001 one cycle later.
- Backpressure/gaps: num_beats=3 with valid toggled 1,0,1,0,1.
  - Required: exactly 3 beats captured, done on the cycle after the third handshake, and ready=0 thereafter even with valid held high.
- Clamp: num_beats=0.
  - Required: one beat accepted, then done.
- Clamp: num_beats=31 with DEPTH=16.
  - Required: 16 beats accepted, then done; ready never rises again.
- Restart mid-run: after 1 of 4 beats, pulse start while valid=1.
  - Required: ready=0 that cycle, count=0; the next beat lands in slot 0; reading addr 8 (old beat 1 region) returns 0.
- Reset mid-collection after 2 beats, then start with num_beats=1 and one beat of value 0xAB in all lanes.
  - Required: addr 0 reads 0xAB, addr 8 reads 0, done=1.
